axi_wr_rr_scheduler: RTL
========================

// Module: axi_wr_rr_scheduler
// PURPOSE
// - Write-path master scheduler for the AXI bus interconnect.
// - Grants the shared AW/W bus to one of 2**M_WIDTH masters, round-robin.
// - Gates each master by its count of outstanding B responses.
// - Drives the AW, W and B master-select lines consumed by the master switch.
// PARAMETERS
// - M_ID      2     master-local ID width; the bus ID is {master_idx, local_id}, M_WIDTH+M_ID bits wide
// - M_WIDTH   2     log2 of the master count
// - MAX_OUTS  4     maximum outstanding writes (AW accepted, B not yet returned) per master; must be >= 1
// - WDT_CYCLES 1024 stall limit for the watchdog option
// PORTS
// - BUS_CLK              in   1               bus clock
// - BUS_RSTN             in   1               asynchronous active-low reset
// - MASTER_WR_ADDR_VALID in   2**M_WIDTH      per-master AW valid (request lines)
// - BUS_WR_ADDR_VALID    in   1               muxed AW valid
// - BUS_WR_ADDR_READY    in   1               muxed AW ready
// - BUS_WR_DATA_VALID    in   1               muxed W valid
// - BUS_WR_DATA_READY    in   1               muxed W ready
// - BUS_WR_DATA_LAST     in   1               muxed W last
// - BUS_WR_BACK_ID       in   M_WIDTH+M_ID    B response ID
// - BUS_WR_BACK_VALID    in   1               B valid
// - BUS_WR_BACK_READY    in   1               B ready
// - wr_addr_master_sel   out  M_WIDTH         AW mux select (registered)
// - wr_data_master_sel   out  M_WIDTH         W mux select (registered)
// - wr_resp_master_sel   out  M_WIDTH         B demux select (combinational)
// - wr_busy              out  1               1 while the FSM is not in ARB
// - resp_err             out  1               sticky: B returned for a master whose count is 0
// - wdt_timeout          out  1               sticky watchdog flag; tied 0 when the option is off
// BEHAVIOUR
// - Reset: state=ARB, both registered sels=0, last_grant=all-ones (master 0 wins first).
//   All counters=0, wr_busy=0, resp_err=0, wdt_timeout=0.
// - FSM ARB:
//   - Eligible masters: MASTER_WR_ADDR_VALID[m] && outs[m] < MAX_OUTS.
//   - Winner: first eligible master scanning from last_grant+1, with modulo wrap.
//   - If a winner exists: register wr_addr_master_sel=wr_data_master_sel=winner and go to ADDR.
//   - Otherwise stay in ARB.
//   - One-cycle arbitration latency; sels hold their last value while in ARB.
// - FSM ADDR: on BUS_WR_ADDR_VALID && BUS_WR_ADDR_READY, go to DATA and increment outs[sel].
// - FSM DATA:
//   - On BUS_WR_DATA_VALID && BUS_WR_DATA_READY && BUS_WR_DATA_LAST: go to ARB and set last_grant=sel.
//   - Exactly one burst owns W at a time; AW/W overlap between masters is not supported.
// - Selects are stable from ARB exit to DATA exit; they never change mid-burst.
// - wr_resp_master_sel = BUS_WR_BACK_ID[M_WIDTH+M_ID-1:M_ID]; zero latency, independent of the FSM.
// - outs[m], width $clog2(MAX_OUTS+1):
//   - Decrements on BUS_WR_BACK_VALID && BUS_WR_BACK_READY with ID index m.
//   - Same-cycle increment and decrement on one master leaves the count unchanged.
//   - A decrement at 0 holds 0 and sets resp_err.
//   - The count cannot exceed MAX_OUTS, because the ARB gating prevents it.
// - B responses are accepted in every FSM state.
// - Reset mid-burst: everything returns to reset values immediately. Counters are lost, so masters must also be reset.
// CONFIGURATION
// - Macro AXI_WR_ARB_WDT_EN defined:
//   - A 32-bit counter clears on every state change and on any AW/W handshake.
//   - It increments otherwise while in ADDR or DATA.
//   - Reaching WDT_CYCLES sets wdt_timeout (sticky until reset).
//   - Diagnostic only; the FSM is not disturbed.
// - Macro AXI_WR_ARB_WDT_EN undefined: no counter logic; wdt_timeout is constant 0.
// STRUCTURE
// - Package axi_arb_pkg:
//   - typedef enum logic [1:0] {ARB, ADDR, DATA} wr_arb_state_t.
//   - Function rr_next(req, last) for rotate-priority selection.
// - Sub-module axi_rr_pick: combinational rotate-priority encoder.
//   - Inputs: eligible vector and last_grant. Outputs: found and winner index.
//   - The read-side scheduler reuses it.
// TESTING
// 1. Reset, then req=4'b0001: sel=0 one cycle after ARB; AW hs gives outs[0]=1; B with ID 4'b0000 gives outs[0]=0.
// 2. Rotation: req=4'b1111 held with 1-beat bursts and B returned each time: grant order 0,1,2,3,0.
// 3. Credit gate: master 1 issues 4 AWs with no B, req=4'b0010.
//    - FSM stays in ARB.
//    - B ID=4'b0100 makes outs[1]=3, and master 1 is granted the next cycle.
// 4. Simultaneous events: AW hs for master 2 in the same cycle as B ID=4'b1000 with outs[2]=1: outs[2] stays 1.
//    Also check B ID=4'b1100 while outs[3]=0: resp_err goes to 1.
// 5. Burst hold: 8-beat W with READY toggled 50%, and other requests raised: wr_data_master_sel is constant until the LAST handshake.
// 6. BUS_RSTN low in DATA, beat 3 of 8: all outputs return to reset values asynchronously.
//    With AXI_WR_ARB_WDT_EN and WDT_CYCLES=16, AW READY held low for 16 cycles sets wdt_timeout.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and the rotate-priority helper for the AXI write/read master schedulers.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } wr_arb_state_t;

  // Widest request vector rr_next can scan; callers zero-extend into it.
  localparam int unsigned RR_MAX_REQ = 64;
  localparam int unsigned RR_IDX_W   = $clog2(RR_MAX_REQ);

  // First set bit of req[n-1:0] scanning upward from last+1 with wrap.
  // Returns last when req is empty; callers gate with |req.
  function automatic int unsigned rr_next(input logic [RR_MAX_REQ-1:0] req,
                                          input int unsigned           last,
                                          input int unsigned           n);
    int unsigned pick;
    pick = last;
    // Descending scan so the smallest offset from last is the final assignment.
    for (int unsigned k = RR_MAX_REQ; k >= 1; k--) begin
      if (k <= n && req[RR_IDX_W'((last + k) % n)]) begin
        pick = (last + k) % n;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axi_rr_pick.sv
// Combinational rotate-priority encoder shared by the write and read schedulers.
module axi_rr_pick
  import axi_arb_pkg::*;
#(
  parameter int N_WIDTH = 2
) (
  input  logic [2**N_WIDTH-1:0] eligible,
  input  logic [N_WIDTH-1:0]    last_grant,
  output logic                  found,
  output logic [N_WIDTH-1:0]    winner
);

  localparam int unsigned N_REQ = 2**N_WIDTH;

  assign found  = |eligible;
  assign winner = N_WIDTH'(rr_next(RR_MAX_REQ'(eligible), 32'(last_grant), N_REQ));

endmodule

// File: rtl/axi_wr_rr_scheduler.sv
// Write-path round-robin master scheduler with per-master outstanding-B credit gating.
// Optional stall watchdog enabled by defining AXI_WR_ARB_WDT_EN.
module axi_wr_rr_scheduler
  import axi_arb_pkg::*;
#(
  parameter int M_ID       = 2,
  parameter int M_WIDTH    = 2,
  parameter int MAX_OUTS   = 4,
  parameter int WDT_CYCLES = 1024
) (
  input  logic                    BUS_CLK,
  input  logic                    BUS_RSTN,
  input  logic [2**M_WIDTH-1:0]   MASTER_WR_ADDR_VALID,
  input  logic                    BUS_WR_ADDR_VALID,
  input  logic                    BUS_WR_ADDR_READY,
  input  logic                    BUS_WR_DATA_VALID,
  input  logic                    BUS_WR_DATA_READY,
  input  logic                    BUS_WR_DATA_LAST,
  input  logic [M_WIDTH+M_ID-1:0] BUS_WR_BACK_ID,
  input  logic                    BUS_WR_BACK_VALID,
  input  logic                    BUS_WR_BACK_READY,
  output logic [M_WIDTH-1:0]      wr_addr_master_sel,
  output logic [M_WIDTH-1:0]      wr_data_master_sel,
  output logic [M_WIDTH-1:0]      wr_resp_master_sel,
  output logic                    wr_busy,
  output logic                    resp_err,
  output logic                    wdt_timeout
);

  localparam int N_MST = 2**M_WIDTH;
  localparam int CNT_W = $clog2(MAX_OUTS + 1);
  localparam logic [CNT_W-1:0] OUTS_MAX = CNT_W'(MAX_OUTS);

  wr_arb_state_t      state_q, state_d;
  logic [M_WIDTH-1:0] sel_q, sel_d;
  logic [M_WIDTH-1:0] last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   outs_q [N_MST];
  logic               resp_err_q;

  logic [N_MST-1:0]   eligible;
  logic [N_MST-1:0]   inc_vec, dec_vec, zero_vec;
  logic               found;
  logic [M_WIDTH-1:0] winner;
  logic               aw_hs, w_last_hs, b_hs;
  logic [M_WIDTH-1:0] b_idx;
  logic               err_hit;
  logic               unused_local_id;

  assign aw_hs     = (state_q == ADDR) && BUS_WR_ADDR_VALID && BUS_WR_ADDR_READY;
  assign w_last_hs = (state_q == DATA) && BUS_WR_DATA_VALID && BUS_WR_DATA_READY && BUS_WR_DATA_LAST;
  assign b_hs      = BUS_WR_BACK_VALID && BUS_WR_BACK_READY;
  assign b_idx     = BUS_WR_BACK_ID[M_WIDTH+M_ID-1:M_ID];
  assign unused_local_id = ^BUS_WR_BACK_ID[M_ID-1:0];

  // NOTE: always_comb assigns every output a default before any branch, so no latch is inferred.
  always_comb begin
    eligible = '0;
    inc_vec  = '0;
    dec_vec  = '0;
    zero_vec = '0;
    for (int m = 0; m < N_MST; m++) begin
      eligible[m] = MASTER_WR_ADDR_VALID[m] && (outs_q[m] < OUTS_MAX);
      inc_vec[m]  = aw_hs && (sel_q == M_WIDTH'(m));
      dec_vec[m]  = b_hs && (b_idx == M_WIDTH'(m));
      zero_vec[m] = (outs_q[m] == '0);
    end
  end

  // A response with nothing outstanding is an error unless the same master's AW lands this cycle.
  assign err_hit = |(dec_vec & ~inc_vec & zero_vec);

  axi_rr_pick #(
    .N_WIDTH (M_WIDTH)
  ) u_pick (
    .eligible   (eligible),
    .last_grant (last_grant_q),
    .found      (found),
    .winner     (winner)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      ARB: begin
        if (found) begin
          sel_d   = winner;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (aw_hs) state_d = DATA;
      end
      DATA: begin
        if (w_last_hs) begin
          state_d      = ARB;
          last_grant_d = sel_q;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge BUS_CLK or negedge BUS_RSTN) begin
    if (!BUS_RSTN) begin
      state_q      <= ARB;
      sel_q        <= '0;
      last_grant_q <= '1;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  // NOTE: the credit array is control state, not storage, so every entry is reset.
  always_ff @(posedge BUS_CLK or negedge BUS_RSTN) begin
    if (!BUS_RSTN) begin
      for (int m = 0; m < N_MST; m++) outs_q[m] <= '0;
      resp_err_q <= 1'b0;
    end else begin
      for (int m = 0; m < N_MST; m++) begin
        unique case ({inc_vec[m], dec_vec[m]})
          2'b10:   outs_q[m] <= outs_q[m] + CNT_W'(1);
          2'b01:   if (!zero_vec[m]) outs_q[m] <= outs_q[m] - CNT_W'(1);
          default: outs_q[m] <= outs_q[m];
        endcase
      end
      if (err_hit) resp_err_q <= 1'b1;
    end
  end

`ifdef AXI_WR_ARB_WDT_EN
  localparam logic [31:0] WDT_LIMIT = 32'(WDT_CYCLES);

  logic [31:0] wdt_cnt_q;
  logic        wdt_q;
  logic        wdt_clear;

  // Any forward progress on AW or W, or any FSM move, restarts the stall count.
  assign wdt_clear = (state_d != state_q)
                   || (BUS_WR_ADDR_VALID && BUS_WR_ADDR_READY)
                   || (BUS_WR_DATA_VALID && BUS_WR_DATA_READY);

  always_ff @(posedge BUS_CLK or negedge BUS_RSTN) begin
    if (!BUS_RSTN) begin
      wdt_cnt_q <= '0;
      wdt_q     <= 1'b0;
    end else if (wdt_clear) begin
      wdt_cnt_q <= '0;
    end else if ((state_q != ARB) && (wdt_cnt_q < WDT_LIMIT)) begin
      wdt_cnt_q <= wdt_cnt_q + 32'd1;
      if (wdt_cnt_q == WDT_LIMIT - 32'd1) wdt_q <= 1'b1;
    end
  end

  assign wdt_timeout = wdt_q;
`else
  localparam int unused_wdt_cycles = WDT_CYCLES;
  assign wdt_timeout = 1'b0;
`endif

  // AW and W always follow the same owner, so one select register feeds both.
  assign wr_addr_master_sel = sel_q;
  assign wr_data_master_sel = sel_q;
  assign wr_resp_master_sel = b_idx;
  assign wr_busy            = (state_q != ARB);
  assign resp_err           = resp_err_q;

endmodule
